// File: rtl/ccr_result_queue.sv
// Result queue behind the 32-bit adder: buffers {N,Z,C,V,sum} entries, commits NZCV to the CCR
// in order as entries leave, and evaluates the branch condition. Optional macro: STICKY_OVF_EN.
module ccr_result_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [35:0]   in_bus,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flags_we,
    output logic [31:0]   out_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    ccr,
    input  logic [1:0]    cond_sel,
    output logic          cond_met,
`ifdef STICKY_OVF_EN
    input  logic          sov_clr,
    output logic          sov,
`endif
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [36:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    ccr_q, ccr_d;
    logic [36:0]   head;
    logic          push, pop, commit;

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // in_ready depends only on registered occupancy (and reset), never on out_ready,
    // so a full queue refuses a push even in a cycle where it also pops.
    assign in_ready  = clr && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head       = mem_q[rd_ptr_q];
    assign out_result = out_valid ? head[31:0] : 32'h0;
    assign commit     = pop && head[36];
    assign count      = count_q;
    assign ccr        = ccr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ccr_d    = ccr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (commit) ccr_d = head[35:32];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ccr_q    <= 4'b0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ccr_q    <= ccr_d;
        end
    end

    // Storage needs no reset: out_result is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {flags_we, in_bus};
    end

    always_comb begin
        cond_met = 1'b0;
        case (cond_sel)
            2'b00: cond_met = ccr_q[2];
            2'b01: cond_met = !ccr_q[2];
            2'b10: cond_met = !ccr_q[3];
            2'b11: cond_met = ccr_q[3];
            default: cond_met = 1'b0;
        endcase
    end

`ifdef STICKY_OVF_EN
    logic sov_q, sov_d;

    // A committing overflow beats a same-cycle clear.
    always_comb begin
        sov_d = sov_q;
        if (commit && head[32]) sov_d = 1'b1;
        else if (sov_clr)       sov_d = 1'b0;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) sov_q <= 1'b0;
        else      sov_q <= sov_d;
    end

    assign sov = sov_q;
`endif

endmodule

// File: tb/tb_ccr_result_queue.sv
// Self-checking bench for ccr_result_queue: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_ccr_result_queue;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [35:0] in_bus = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flags_we = 1'b0;
    logic [31:0] out_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  ccr;
    logic [1:0]  cond_sel = 2'b01;
    logic        cond_met;
    logic [AW:0] count;
`ifdef STICKY_OVF_EN
    logic        sov_clr = 1'b0;
    logic        sov;
`endif

    ccr_result_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .clr(clr),
        .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready), .flags_we(flags_we),
        .out_result(out_result), .out_valid(out_valid), .out_ready(out_ready),
        .ccr(ccr), .cond_sel(cond_sel), .cond_met(cond_met),
`ifdef STICKY_OVF_EN
        .sov_clr(sov_clr), .sov(sov),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: each entry is {flags_we, N, Z, C, V, sum}.
    logic [36:0] exp_q[$];
    logic [3:0]  m_ccr = 4'b0000;
    logic        m_sov = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_cond(input logic [1:0] sel, input logic [3:0] flags);
        logic n_flag, z_flag;
        n_flag = flags[3];
        z_flag = flags[2];
        case (sel)
            2'b00:   return z_flag;
            2'b01:   return !z_flag;
            2'b10:   return !n_flag;
            default: return n_flag;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},   36'(in_ready),   36'(clr && exp_q.size() < DEPTH));
        chk({tag, ".out_valid"},  36'(out_valid),  36'(exp_q.size() != 0));
        chk({tag, ".out_result"}, 36'(out_result), (exp_q.size() != 0) ? 36'(exp_q[0][31:0]) : 36'h0);
        chk({tag, ".count"},      36'(count),      36'(exp_q.size()));
        chk({tag, ".ccr"},        36'(ccr),        36'(m_ccr));
        chk({tag, ".cond_met"},   36'(cond_met),   36'(model_cond(cond_sel, m_ccr)));
`ifdef STICKY_OVF_EN
        chk({tag, ".sov"},        36'(sov),        36'(m_sov));
`endif
    endtask

    // Advance one clock; called at a falling edge, returns at the next falling edge.
    task automatic tick();
        bit          do_push, do_pop;
        logic [36:0] e;
        logic [36:0] incoming;
        bit          clr_req;
        do_push  = clr && in_valid && (exp_q.size() < DEPTH);
        do_pop   = clr && out_ready && (exp_q.size() != 0);
        incoming = {flags_we, in_bus};
        clr_req  = 1'b0;
`ifdef STICKY_OVF_EN
        clr_req  = sov_clr;
`endif
        @(posedge clk);
        if (clr) begin
            if (do_pop) begin
                e = exp_q.pop_front();
                if (e[36]) m_ccr = e[35:32];
                if (e[36] && e[32]) m_sov = 1'b1;
                else if (clr_req)   m_sov = 1'b0;
            end else if (clr_req) begin
                m_sov = 1'b0;
            end
            if (do_push) exp_q.push_back(incoming);
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic iv, input logic fw, input logic [35:0] bus,
                        input logic ordy, input logic [1:0] cs);
        in_valid  = iv;
        flags_we  = fw;
        in_bus    = bus;
        out_ready = ordy;
        cond_sel  = cs;
        #1;
        check_all(tag);
        tick();
    endtask

    task automatic apply_reset();
        #2;
        clr = 1'b0;
        exp_q.delete();
        m_ccr = 4'b0000;
        m_sov = 1'b0;
        #1;
        check_all("reset_async");
        @(negedge clk);
        check_all("reset_held");
        clr = 1'b1;
    endtask

    initial begin
        logic [35:0] rbus;
        // Test 1: reset state
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("t1_in_ready_in_reset", 36'(in_ready), 36'h0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("t1_count", 36'(count), 36'h0);
        chk("t1_in_ready", 36'(in_ready), 36'h1);
        chk("t1_out_valid", 36'(out_valid), 36'h0);
        chk("t1_ccr", 36'(ccr), 36'h0);
        chk("t1_cond_met", 36'(cond_met), 36'h1);
        check_all("t1");
        @(negedge clk);

        // Test 2: one flag-writing entry, pop commits Z
        step("t2_push", 1'b1, 1'b1, 36'h4_0000_0000, 1'b1, 2'b00);
        chk("t2_valid_after_push", 36'(out_valid), 36'h1);
        step("t2_pop", 1'b0, 1'b0, 36'hx, 1'b1, 2'b00);
        chk("t2_ccr", 36'(ccr), 36'h4);
        chk("t2_cond_zr", 36'(cond_met), 36'h1);

        // Test 3: fill past capacity, drain in order
        step("t3_a", 1'b1, 1'b0, 36'h0_0000_0011, 1'b0, 2'b01);
        step("t3_b", 1'b1, 1'b0, 36'h0_0000_0022, 1'b0, 2'b01);
        step("t3_c", 1'b1, 1'b0, 36'h0_0000_0033, 1'b0, 2'b01);
        chk("t3_full_in_ready", 36'(in_ready), 36'h0);
        chk("t3_full_count", 36'(count), 36'h2);
        chk("t3_head0", 36'(out_result), 36'h11);
        step("t3_pop0", 1'b1, 1'b0, 36'h0_0000_0044, 1'b1, 2'b01);
        chk("t3_head1", 36'(out_result), 36'h22);
        step("t3_pop1", 1'b0, 1'b0, 36'hx, 1'b1, 2'b01);
        chk("t3_empty", 36'(count), 36'h0);

        // Test 4: result-only entry leaves CCR alone
        step("t4_push", 1'b1, 1'b0, 36'h8_8000_0000, 1'b0, 2'b11);
        chk("t4_result", 36'(out_result), 36'h8000_0000);
        step("t4_pop", 1'b0, 1'b0, 36'hx, 1'b1, 2'b11);
        chk("t4_ccr", 36'(ccr), 36'h4);
        chk("t4_cond_mi", 36'(cond_met), 36'h0);

        // Test 5: simultaneous push/pop at count=1, then reset mid-stream
        step("t5_fill", 1'b1, 1'b1, 36'h1_0000_0055, 1'b0, 2'b10);
        step("t5_both", 1'b1, 1'b1, 36'h9_0000_0066, 1'b1, 2'b10);
        chk("t5_count_held", 36'(count), 36'h1);
        in_valid = 1'b1;
        apply_reset();
        chk("t5_count_reset", 36'(count), 36'h0);
        chk("t5_ccr_reset", 36'(ccr), 36'h0);
        in_valid = 1'b0;
        @(negedge clk);

`ifdef STICKY_OVF_EN
        // Test 6: sticky overflow
        step("t6_v1", 1'b1, 1'b1, 36'h1_0000_0001, 1'b1, 2'b00);
        step("t6_v0", 1'b1, 1'b1, 36'h0_0000_0002, 1'b1, 2'b00);
        step("t6_pop", 1'b0, 1'b0, 36'hx, 1'b1, 2'b00);
        chk("t6_sov_set", 36'(sov), 36'h1);
        sov_clr = 1'b1;
        step("t6_clr", 1'b0, 1'b0, 36'hx, 1'b1, 2'b00);
        sov_clr = 1'b0;
        chk("t6_sov_cleared", 36'(sov), 36'h0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rbus = {4'($urandom_range(0, 15)), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) rbus = 36'hx;
`ifdef STICKY_OVF_EN
            sov_clr = ($urandom_range(0, 7) == 0);
`endif
            step("rand", (rbus !== 36'hx) && ($urandom_range(0, 1) == 1),
                 1'($urandom_range(0, 1)), rbus,
                 1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
            if (i == 250) apply_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
